// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite scheduler: FSM states,
// the sprite descriptor layout and the horizontal blanking budget.
package sprite_sched_pkg;

  localparam int SPR_CORDW      = 10;
  localparam int H_BLANK_CYCLES = 160;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                 en;
    logic [SPR_CORDW-1:0] x;
    logic [SPR_CORDW-1:0] y;
  } spr_desc_t;

endpackage

// File: rtl/sched_first_free.sv
// Priority encoder: index of the lowest-numbered engine that is not busy,
// plus a flag telling whether any engine is free at all.
module sched_first_free #(
  parameter  int N_ENG = 4,
  localparam int EW    = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
  input  logic [N_ENG-1:0] busy,
  output logic [EW-1:0]    free_idx,
  output logic             any_free
);

  // Walk from the top down so the lowest free index is the one that sticks.
  always_comb begin
    free_idx = '0;
    any_free = |(~busy);
    for (int k = N_ENG - 1; k >= 0; k--) begin
      free_idx = busy[k] ? free_idx : EW'(k);
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Hands sprites whose top line is the next line to free sprite engines
// during horizontal blanking, using double-buffered descriptor banks.
module sprite_scheduler
  import sprite_sched_pkg::*;
#(
  parameter  int CORDW      = SPR_CORDW,
  parameter  int N_SPR      = 16,
  parameter  int N_ENG      = 4,
  parameter  int V_RES_FULL = 525,
  localparam int AW         = (N_SPR > 1) ? $clog2(N_SPR) : 1,
  localparam int EW         = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame,
  input  logic                   line,
  input  logic [CORDW-1:0]       sy,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [CORDW-1:0]       cfg_x,
  input  logic [CORDW-1:0]       cfg_y,
  input  logic                   cfg_en,
  input  logic [N_ENG-1:0]       eng_done,
  output logic [N_ENG-1:0]       eng_start,
  output logic [N_ENG*CORDW-1:0] eng_sprx,
  output logic [N_ENG-1:0]       eng_busy,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  sched_state_e                  state_q, state_d;
  logic [AW-1:0]                 idx_q, idx_d;
  spr_desc_t                     pend_q [N_SPR];
  spr_desc_t                     pend_d [N_SPR];
  spr_desc_t                     act_q  [N_SPR];
  spr_desc_t                     act_d  [N_SPR];
  logic [N_ENG-1:0]              busy_q, busy_d;
  logic [N_ENG-1:0]              start_q, start_d;
  logic [N_ENG-1:0][CORDW-1:0]   sprx_q, sprx_d;
  logic                          ovf_q, ovf_d;

  logic [CORDW-1:0]              tgt_s;
  spr_desc_t                     cur_s;
  logic                          match_s;
  logic                          alloc_s;
  logic                          drop_s;
  logic                          late_line_s;
  logic                          addr_ok_s;
  logic [EW-1:0]                 free_idx_s;
  logic                          any_free_s;

  sched_first_free #(
    .N_ENG (N_ENG)
  ) u_first_free (
    .busy     (busy_q),
    .free_idx (free_idx_s),
    .any_free (any_free_s)
  );

  // The line after the last line of the frame is line 0.
  assign tgt_s     = (sy == CORDW'(V_RES_FULL - 1)) ? '0 : sy + CORDW'(1);
  assign addr_ok_s = ({1'b0, cfg_addr} < (AW + 1)'(N_SPR));
  assign cur_s     = act_q[idx_q];
  assign match_s   = (state_q == SCAN) && cur_s.en &&
                     (cur_s.y == SPR_CORDW'(tgt_s));

  // Descriptor banks: active takes the old pending contents on frame.
  always_comb begin
    pend_d = pend_q;
    if (frame) begin
      act_d = pend_q;
    end else begin
      act_d = act_q;
    end
    if (cfg_we && addr_ok_s) begin
      pend_d[cfg_addr] = '{en: cfg_en, x: SPR_CORDW'(cfg_x), y: SPR_CORDW'(cfg_y)};
    end else begin
      pend_d = pend_q;
    end
  end

  // Scan sequencer: one descriptor per cycle after a line pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    late_line_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (line) begin
          state_d = SCAN;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        late_line_s = line;
        if (idx_q == AW'(N_SPR - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Engine allocation, release and sticky overflow.
  always_comb begin
    start_d = '0;
    sprx_d  = sprx_q;
    busy_d  = busy_q & ~eng_done;
    alloc_s = match_s && any_free_s;
    drop_s  = match_s && !any_free_s;
    if (alloc_s) begin
      start_d[free_idx_s] = 1'b1;
      busy_d[free_idx_s]  = 1'b1;
      sprx_d[free_idx_s]  = CORDW'(cur_s.x);
    end else begin
      start_d = '0;
    end
    if (drop_s || late_line_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SPR; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      start_q <= '0;
      sprx_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      start_q <= start_d;
      sprx_q  <= sprx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign eng_start = start_q;
  assign eng_sprx  = sprx_q;
  assign eng_busy  = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a cycle-level reference model
// built from scheduled match times rather than from the scan state machine.
module tb_sprite_scheduler;

  localparam int CORDW      = 10;
  localparam int N_SPR      = 16;
  localparam int N_ENG      = 4;
  localparam int V_RES_FULL = 525;
  localparam int AW         = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   frame = 1'b0;
  logic                   line = 1'b0;
  logic [CORDW-1:0]       sy = '0;
  logic                   cfg_we = 1'b0;
  logic [AW-1:0]          cfg_addr = '0;
  logic [CORDW-1:0]       cfg_x = '0;
  logic [CORDW-1:0]       cfg_y = '0;
  logic                   cfg_en = 1'b0;
  logic [N_ENG-1:0]       eng_done = '0;
  logic [N_ENG-1:0]       eng_start;
  logic [N_ENG*CORDW-1:0] eng_sprx;
  logic [N_ENG-1:0]       eng_busy;
  logic                   overflow;
  logic                   ovf_clr = 1'b0;

  sprite_scheduler #(
    .CORDW(CORDW), .N_SPR(N_SPR), .N_ENG(N_ENG), .V_RES_FULL(V_RES_FULL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .sy(sy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_en(cfg_en), .eng_done(eng_done), .eng_start(eng_start),
    .eng_sprx(eng_sprx), .eng_busy(eng_busy), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { int due; int x; } job_t;
  job_t             jobs[$];
  job_t             job;
  int               m_pend_x [N_SPR];
  int               m_pend_y [N_SPR];
  bit               m_pend_en[N_SPR];
  int               m_act_x  [N_SPR];
  int               m_act_y  [N_SPR];
  bit               m_act_en [N_SPR];
  bit [N_ENG-1:0]   m_busy, m_start, nb;
  int               m_sprx[N_ENG];
  bit               m_ovf, drop, late;
  int               edge_n = 0;
  int               scan_end = -1;
  int               tgt, found;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N_SPR; i++) begin
          m_pend_x[i] = 0; m_pend_y[i] = 0; m_pend_en[i] = 0;
          m_act_x[i] = 0;  m_act_y[i] = 0;  m_act_en[i] = 0;
        end
        for (int k = 0; k < N_ENG; k++) m_sprx[k] = 0;
        m_busy = '0; m_start = '0; m_ovf = 0;
        jobs.delete();
        scan_end = -1;
      end else begin
        drop = 0; late = 0; m_start = '0;
        nb = m_busy & ~eng_done;
        if (jobs.size() > 0 && jobs[0].due == edge_n) begin
          job = jobs.pop_front();
          found = -1;
          for (int k = N_ENG - 1; k >= 0; k--) if (!m_busy[k]) found = k;
          if (found >= 0) begin
            nb[found] = 1'b1; m_start[found] = 1'b1; m_sprx[found] = job.x;
          end else begin
            drop = 1;
          end
        end
        m_busy = nb;
        if (frame) begin
          m_act_x = m_pend_x; m_act_y = m_pend_y; m_act_en = m_pend_en;
        end
        if (cfg_we) begin
          m_pend_x[cfg_addr] = int'(cfg_x);
          m_pend_y[cfg_addr] = int'(cfg_y);
          m_pend_en[cfg_addr] = cfg_en;
        end
        if (line) begin
          if (edge_n <= scan_end) begin
            late = 1;
          end else begin
            scan_end = edge_n + N_SPR;
            tgt = (int'(sy) + 1) % V_RES_FULL;
            for (int i = 0; i < N_SPR; i++)
              if (m_act_en[i] && m_act_y[i] == tgt) jobs.push_back('{edge_n + 1 + i, m_act_x[i]});
          end
        end
        if (drop || late) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
      end
      edge_n++;
      #1;
      chk("start", eng_start, m_start);
      chk("busy", eng_busy, m_busy);
      chk("overflow", overflow, m_ovf);
      for (int k = 0; k < N_ENG; k++) chk("sprx", eng_sprx[k*CORDW +: CORDW], m_sprx[k]);
    end
  end

  // Stimulus helpers, all entered and left at a falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int x, input int y, input bit en);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_x = CORDW'(x); cfg_y = CORDW'(y); cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1; @(negedge clk); frame = 1'b0;
  endtask

  task automatic pulse_line(input int s);
    sy = CORDW'(s); line = 1'b1; @(negedge clk); line = 1'b0;
  endtask

  task automatic done(input logic [N_ENG-1:0] m);
    eng_done = m; @(negedge clk); eng_done = '0;
  endtask

  task automatic clr();
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_start", eng_start, 4'b0000);
    chk("rst_busy", eng_busy, 4'b0000);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_sprx", eng_sprx, 40'd0);
    rst_n = 1'b1;
    cyc(2);

    // Written but not yet promoted by frame: no start
    wr(0, 280, 200, 1);
    pulse_line(199);
    cyc(20);
    chk("noframe_busy", eng_busy, 4'b0000);
    pulse_frame();
    pulse_line(199);
    cyc(1);
    chk("t1_start", eng_start, 4'b0001);
    chk("t1_sprx0", eng_sprx[CORDW-1:0], 10'd280);
    chk("t1_busy", eng_busy, 4'b0001);
    cyc(20);

    // Five sprites on one line, four engines
    done(4'b0001);
    for (int i = 0; i < 5; i++) wr(i, 50 + i * 100, 100, 1);
    pulse_frame();
    pulse_line(99);
    cyc(1);
    chk("multi_start0", eng_start, 4'b0001);
    cyc(1);
    chk("multi_start1", eng_start, 4'b0010);
    cyc(20);
    chk("multi_busy", eng_busy, 4'b1111);
    chk("multi_ovf", overflow, 1'b1);
    chk("multi_sprx3", eng_sprx[4*CORDW-1:3*CORDW], 10'd350);
    clr();
    chk("ovf_cleared", overflow, 1'b0);

    // Release engine 1, next match lands there
    done(4'b0010);
    chk("rel_busy", eng_busy, 4'b1101);
    wr(5, 333, 150, 1);
    pulse_frame();
    pulse_line(149);
    cyc(6);
    chk("rel_start", eng_start, 4'b0010);
    chk("rel_sprx1", eng_sprx[2*CORDW-1:CORDW], 10'd333);
    chk("rel_busy2", eng_busy, 4'b1111);
    cyc(20);

    // Top-line wrap from the last line of the frame
    done(4'b1111);
    wr(6, 77, 0, 1);
    pulse_frame();
    pulse_line(524);
    cyc(7);
    chk("wrap_start", eng_start, 4'b0001);
    chk("wrap_sprx0", eng_sprx[CORDW-1:0], 10'd77);
    cyc(20);

    // Second line five cycles into a scan
    done(4'b0001);
    pulse_line(524);
    cyc(4);
    pulse_line(524);
    cyc(20);
    chk("late_ovf", overflow, 1'b1);
    chk("late_busy", eng_busy, 4'b0001);

    // cfg_we coinciding with frame reaches active only at the next frame
    done(4'b0001);
    cfg_we = 1'b1; cfg_addr = AW'(7); cfg_x = CORDW'(55); cfg_y = CORDW'(300); cfg_en = 1'b1;
    frame = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; frame = 1'b0;
    pulse_line(299);
    cyc(20);
    chk("coll_busy", eng_busy, 4'b0000);
    pulse_frame();
    pulse_line(299);
    cyc(8);
    chk("coll_start", eng_start, 4'b0001);
    chk("coll_sprx0", eng_sprx[CORDW-1:0], 10'd55);
    cyc(5);

    // Reset in the middle of a scan
    done(4'b0001);
    pulse_line(299);
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_start", eng_start, 4'b0000);
    chk("midrst_busy", eng_busy, 4'b0000);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_sprx", eng_sprx, 40'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(25);
    chk("post_rst_busy", eng_busy, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Shares a small pool of N_ENG hardware sprite engines among N_SPR sprite descriptors (x, y, enable), so more sprites can be placed on screen than there are engines.
- In the horizontal blanking of every line, scans the descriptors in order and hands each sprite whose top line is the next line to a free engine, pulsing that engine's start with its x position.
- Sits between the display timing generator and the sprite engine instances in the top level.

Parameters:
- CORDW, 10, screen coordinate width in bits.
- N_SPR, 16, number of sprite descriptors; legal range 1..128 so a scan fits in the 160-cycle horizontal blanking.
- N_ENG, 4, number of sprite engines driven; legal range 1..8.
- V_RES_FULL, 525, total lines per frame including blanking; used for top-line wrap.

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- frame  input  1  one-cycle pulse at the start of vertical blanking (sy==480, sx==0).
- line  input  1  one-cycle pulse at the start of horizontal blanking (sx==640).
- sy  input  CORDW  current line.
- cfg_we  input  1  descriptor write strobe.
- cfg_addr  input  $clog2(N_SPR)  descriptor index.
- cfg_x  input  CORDW  sprite x.
- cfg_y  input  CORDW  sprite top line.
- cfg_en  input  1  sprite enable.
- eng_done  input  N_ENG  one-cycle pulse from an engine when its last line is drawn.
- eng_start  output  N_ENG  one-cycle start pulse per engine.
- eng_sprx  output  N_ENG*CORDW  x position per engine, held from start until the next assignment.
- eng_busy  output  N_ENG  engine-allocated flags.
- overflow  output  1  sticky: a sprite was dropped because no engine was free, or a scan overran.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (async, rst_n low): all outputs 0, both descriptor banks cleared (all disabled), state IDLE.
- Two descriptor banks, pending and active.
  - cfg_we writes the pending bank on the next clock edge.
  - On frame, the pending bank is copied to the active bank. This gives tear-free updates.
  - A cfg_we coinciding with frame: the new value is written to pending; active receives the old pending value. The new value reaches active at the next frame.
- Target line: tgt = (sy==V_RES_FULL-1) ? 0 : sy+1, computed combinationally. A sprite matches when active.en && active.y==tgt.
- State machine:
  - IDLE: on line go to SCAN with idx=0.
  - SCAN: examine descriptor idx each cycle. After idx==N_SPR-1, go to IDLE.
- Timing: line at cycle t means descriptor i is examined at t+1+i, and any eng_start for it is registered high at t+2+i for one cycle.
- Allocation on a match:
  - Choose the lowest-index engine with eng_busy==0.
  - Set eng_busy[k]; pulse eng_start[k]; load eng_sprx[k]=x.
  - Lower descriptor index wins, because the scan is in order.
  - Match with no free engine: set overflow; the sprite is skipped for this frame.
- Release:
  - eng_done[k] clears eng_busy[k] at the next edge; that engine is allocatable from the following cycle.
  - eng_done and allocation of the same engine can never coincide, because the engine is still busy in that cycle.
  - eng_done on an idle engine is ignored.
- line arriving while in SCAN: ignored (scan continues) and overflow is set.
- frame does not abort a scan or free any engine.
- ovf_clr clears overflow. If a set condition occurs in the same cycle as ovf_clr, set wins.
- At most one eng_start bit is high per cycle.

Decomposition:
- Package sprite_sched_pkg holds:
  - state enum {IDLE, SCAN};
  - packed struct spr_desc_t {logic en; logic [CORDW-1:0] x, y};
  - the H blanking budget constant (160).
- Sub-module sched_first_free: combinational priority encoder from eng_busy to free index plus any_free.

Test Plan:
- Write sprite 0 (x=280, y=200, en=1), pulse frame, then line at sy=199: eng_start[0] high exactly 2 cycles after line; eng_sprx[0]=280; eng_busy=0001.
- Sprite 0 starts on engine 0 without a preceding frame: no eng_start; after frame it starts on the next matching line.
- N_ENG=4; sprites 0..4 all with y=100: at line sy=99, engines 0..3 start on consecutive cycles for descriptors 0..3; descriptor 4 dropped; overflow=1; ovf_clr then clears it.
- eng_done[1] pulse, then a new match: next allocation uses engine 1 (lowest free); eng_busy=1111 again.
- Sprite with y=0 and sy=524 then line: start issued (wrap). rst_n low mid-SCAN: all outputs 0 immediately, no further starts.
- Second line pulse 5 cycles after the first with N_SPR=16: scan completes unchanged and overflow=1.
